vga_scan_engine: RTL
====================

# vga_scan_engine

Parametrised VGA scan-out engine for the vector-processor top level: generates pixel clock, horizontal/vertical sync and the pixel-read stream from the image memory. It converts each 8-bit grayscale sample to 24-bit RGB using per-channel switch gains. It generalises the fixed 640x480 output stage with configurable timing, pixel-clock division, image window size, memory read latency and frame-aligned enable.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync, back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync (lines)
- CLK_DIV, 2, system clocks per pixel; even, >= 2
- MEM_LAT, 1, image-memory read latency in clocks; must be < CLK_DIV
- IMG_W / IMG_H, 256 / 256, image window, top-left aligned; must be <= H_ACTIVE / V_ACTIVE
- ADDR_W, 16, pix_addr width; 2^ADDR_W >= IMG_W*IMG_H
- PIX_W, 8, bits per sample and per output channel

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- en  in  1  scan enable, frame-aligned (see Operation)
- red_gain / green_gain / blue_gain  in  2 each  channel gain select
- pix_rd  out  1  one-clock read strobe to image memory
- pix_addr  out  ADDR_W  read address, valid while pix_rd=1
- pix_data  in  PIX_W  read data, valid MEM_LAT clocks after pix_rd
- rgb  out  3*PIX_W  {R,G,B}, R in MSBs
- h_sync / v_sync  out  1 each  active-low syncs
- vga_clk  out  1  pixel clock
- frame_start  out  1  one-clock pulse at first pixel of each frame
- active  out  1  high while the presented pixel is in the visible area

## Operation
- Divider counts 0..CLK_DIV-1; pixel tick when divider == 0. vga_clk = 1 for divider < CLK_DIV/2, else 0.
- h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H params), advances on tick; v_cnt 0..V_TOTAL-1 advances on tick when h_cnt wraps. Visible area: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE, porches/sync follow in order FP, SYNC, BP.
- Sync region: h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); same scheme for v_cnt.
- On a tick at position (x,y) inside image window (x<IMG_W, y<IMG_H): pix_rd=1 for that clock, pix_addr = running address. Address is incremental (no multiplier): +1 after each read, cleared to 0 at frame start (x=0,y=0). Result equals y*IMG_W + x.
- Visible pixels outside the window: no read, sample forced to 0. Blanking: no read, rgb = 0.
- pix_data captured MEM_LAT clocks after pix_rd.
- Channel gain g applied to sample s: 0 -> 0, 1 -> s>>2, 2 -> s>>1, 3 -> s. Gains sampled at capture time.
- en: scanning starts only when en=1 at the frame boundary (x=0,y=0). Deasserting en mid-frame completes the current frame. At the next boundary the engine idles: counters held at 0, no reads, rgb=0, syncs high, active=0, frame_start=0. vga_clk keeps toggling while idle.

## Timing
- Reset (rst=0 at clk edge): divider, h_cnt, v_cnt, address = 0. Outputs: rgb=0, h_sync=1, v_sync=1, vga_clk=0, pix_rd=0, pix_addr=0, frame_start=0, active=0. Reset mid-frame aborts immediately; in-flight reads are discarded.
- First tick after reset release with en=1 starts pixel (0,0).
- Output latency: one pixel period. rgb, h_sync, v_sync and active for position (x,y) all update together on the tick after the tick that issued (x,y). Syncs are delayed to stay aligned with data.
- frame_start pulses on the clock where outputs for (0,0) appear.
- pix_rd is at most one clock per pixel period; never asserted in blanking or idle.
- Simultaneous h and v wrap: v_cnt wraps to 0, address clears, new frame evaluated against en in the same tick.

## Test plan
- Small config (H 8/2/2/2, V 4/1/1/1, CLK_DIV 2, MEM_LAT 1, IMG 4x2), memory model returns addr as data. With en=1 and all gains 3: rows 0-1 show rgb = {a,a,a} for a = 0..7. Pixels x>=4 and rows 2-3 are 0. h_sync low for exactly 2 pixel periods per line, v_sync low for exactly 1 line.
- Gain sweep: sample 0xC8 with red=1, green=2, blue=0 -> rgb = 0x326400.
- CLK_DIV 4, MEM_LAT 3: vga_clk high 2 / low 2 clocks. Data captured exactly 3 clocks after pix_rd and appears on the next tick. No read outside the window.
- Drop en at mid-frame (line 1): frame completes with correct addresses 0..7. Next boundary goes idle with pix_rd=0, syncs=1, rgb=0. Re-raise en mid-idle: scanning restarts only at the next boundary, with frame_start pulse and address 0.
- Assert rst for 1 clock mid-line: next clock shows all reset values. After release, scanning resumes at (0,0) and the first pix_addr is 0.
- Default 640x480 config: count clocks between frame_start pulses = 800*525*2 = 840000.

Source files
------------

// File: rtl/vga_scan_engine.sv
// VGA scan-out engine: pixel divider, raster counters, image-memory read stream,
// per-channel gain and sync/data alignment with frame-aligned enable.
module vga_scan_engine #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned IMG_W    = 256,
    parameter int unsigned IMG_H    = 256,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned PIX_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           red_gain,
    input  logic [1:0]           green_gain,
    input  logic [1:0]           blue_gain,
    output logic                 pix_rd,
    output logic [ADDR_W-1:0]    pix_addr,
    input  logic [PIX_W-1:0]     pix_data,
    output logic [3*PIX_W-1:0]   rgb,
    output logic                 h_sync,
    output logic                 v_sync,
    output logic                 vga_clk,
    output logic                 frame_start,
    output logic                 active
);

    localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HC_W      = $clog2(H_TOTAL);
    localparam int unsigned VC_W      = $clog2(V_TOTAL);
    localparam int unsigned DIV_W     = $clog2(CLK_DIV);
    localparam int unsigned H_SYNC_LO = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_HI = H_SYNC_LO + H_SYNC;
    localparam int unsigned V_SYNC_LO = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_HI = V_SYNC_LO + V_SYNC;

    typedef enum logic {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;

    state_t              state, state_nxt;
    logic [DIV_W-1:0]    div;
    logic [HC_W-1:0]     h_cnt;
    logic [VC_W-1:0]     v_cnt;
    logic [ADDR_W-1:0]   addr;
    logic [MEM_LAT-1:0]  rd_pipe;
    logic [3*PIX_W-1:0]  px_q;
    logic                s1_vis, s1_win, s1_hs, s1_vs, s1_fs;

    logic                tick_c, origin_c, go_c, h_wrap_c, v_wrap_c;
    logic                vis_c, in_win_c, hs_reg_c, vs_reg_c, cap_c;
    logic [DIV_W-1:0]    div_nxt_c;
    logic [ADDR_W-1:0]   cur_addr_c;
    logic [3*PIX_W-1:0]  gained_c, stage_c;

    function automatic logic [PIX_W-1:0] apply_gain(input logic [1:0] g, input logic [PIX_W-1:0] s);
        case (g)
            2'd0:    return '0;
            2'd1:    return s >> 2;
            2'd2:    return s >> 1;
            default: return s;
        endcase
    endfunction

    assign tick_c     = (div == '0);
    assign div_nxt_c  = (div == DIV_W'(CLK_DIV - 1)) ? '0 : div + DIV_W'(1);
    assign origin_c   = (h_cnt == '0) && (v_cnt == '0);
    assign h_wrap_c   = (h_cnt == HC_W'(H_TOTAL - 1));
    assign v_wrap_c   = (v_cnt == VC_W'(V_TOTAL - 1));
    assign vis_c      = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
    assign in_win_c   = (32'(h_cnt) < IMG_W) && (32'(v_cnt) < IMG_H);
    assign hs_reg_c   = (32'(h_cnt) >= H_SYNC_LO) && (32'(h_cnt) < H_SYNC_HI);
    assign vs_reg_c   = (32'(v_cnt) >= V_SYNC_LO) && (32'(v_cnt) < V_SYNC_HI);
    assign cur_addr_c = origin_c ? '0 : addr;
    assign cap_c      = rd_pipe[MEM_LAT-1];
    assign gained_c   = {apply_gain(red_gain, pix_data), apply_gain(green_gain, pix_data),
                         apply_gain(blue_gain, pix_data)};
    // Data returning on the presenting edge itself bypasses the capture register
    assign stage_c    = cap_c ? gained_c : px_q;

    always_ff @(posedge clk) begin : state_reg
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Run/idle decision is only revisited at the frame boundary
    always_comb begin : next_state
        state_nxt = state;
        if (tick_c && origin_c) state_nxt = en ? S_SCAN : S_IDLE;
    end

    always_comb begin : fsm_out
        go_c = 1'b0;
        if (tick_c) go_c = origin_c ? en : (state == S_SCAN);
    end

    always_ff @(posedge clk) begin : pixel_clock
        if (!rst) begin
            div     <= '0;
            vga_clk <= 1'b0;
        end else begin
            div     <= div_nxt_c;
            vga_clk <= (32'(div) < CLK_DIV / 2);
        end
    end

    always_ff @(posedge clk) begin : raster
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
            addr  <= '0;
        end else if (go_c) begin
            if (h_wrap_c) begin
                h_cnt <= '0;
                v_cnt <= v_wrap_c ? '0 : v_cnt + VC_W'(1);
            end else begin
                h_cnt <= h_cnt + HC_W'(1);
            end
            addr <= in_win_c ? cur_addr_c + ADDR_W'(1) : cur_addr_c;
        end
    end

    always_ff @(posedge clk) begin : read_issue
        if (!rst) begin
            pix_rd   <= 1'b0;
            pix_addr <= '0;
            rd_pipe  <= '0;
            px_q     <= '0;
        end else begin
            pix_rd <= go_c && in_win_c;
            if (go_c && in_win_c) pix_addr <= cur_addr_c;
            rd_pipe[0] <= pix_rd;
            for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
            if (cap_c) px_q <= gained_c;
        end
    end

    // One pixel of delay on position attributes so syncs stay aligned with data
    always_ff @(posedge clk) begin : align_stage
        if (!rst) begin
            s1_vis <= 1'b0;
            s1_win <= 1'b0;
            s1_hs  <= 1'b1;
            s1_vs  <= 1'b1;
            s1_fs  <= 1'b0;
        end else if (tick_c) begin
            s1_vis <= go_c && vis_c;
            s1_win <= go_c && in_win_c;
            s1_hs  <= !(go_c && hs_reg_c);
            s1_vs  <= !(go_c && vs_reg_c);
            s1_fs  <= go_c && origin_c;
        end
    end

    always_ff @(posedge clk) begin : present
        if (!rst) begin
            rgb         <= '0;
            h_sync      <= 1'b1;
            v_sync      <= 1'b1;
            active      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= tick_c && s1_fs;
            if (tick_c) begin
                rgb    <= s1_win ? stage_c : '0;
                h_sync <= s1_hs;
                v_sync <= s1_vs;
                active <= s1_vis;
            end
        end
    end

endmodule
